reg2mem_arbiter: RTL and testbench
==================================

REG2MEM_ARBITER -- requirements
Module: reg2mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  OPW, 2, opcode width
  RGW, 3, register index width
  MAW, 4, memory address width
  DW, 4, data width
  LAT, 2, cycles from dp_en deassertion to valid dp_out (range 1..7)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  single clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  req0, req1  in  1  request from requester 0 / 1, held until done
  op0, op1  in  OPW  requested datapath opcode
  rg0, rg1  in  RGW  requested register index
  ma0, ma1  in  MAW  requested memory address
  din0, din1  in  DW  requested write data
  gnt0, gnt1  out  1  one-cycle grant pulse
  done0, done1  out  1  one-cycle completion pulse
  rdata  out  DW  result of the last completed command
  dp_en  out  1  command strobe to reg2mem datapath
  dp_op  out  OPW  datapath opcode
  dp_reg  out  RGW  datapath register index
  dp_mem  out  MAW  datapath memory address
  dp_din  out  DW  datapath write data
  dp_out  in  DW  datapath result
REQ-003 Datapath opcodes SHALL be: 0 mem[ma] <= din; 1 mem[ma] <= reg[rg]; 2 reg[rg] <= mem[ma]; 3 out <= mem[ma], non-modifying.

Function
REQ-004 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one command in flight at a time.
REQ-005 IDLE: when either req is high, the block SHALL select a winner, latch its op/rg/ma/din, pulse its gnt for one cycle, and enter ISSUE on the next edge.
REQ-006 Arbitration SHALL be round-robin: pointer rr (reset 0) names the preferred requester; if only one requester is high, it wins; after each grant, rr SHALL point to the other requester.
REQ-007 ISSUE: dp_en SHALL be 1 for exactly one cycle, with dp_* driving the latched command; then enter WAIT.
REQ-008 WAIT: a 3-bit counter SHALL count LAT cycles, with dp_en=0 and dp_* held; then enter RESP.
REQ-009 RESP: rdata SHALL load dp_out, the winner's done SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-010 Grant-to-done latency SHALL be LAT+2 cycles; a new grant SHALL NOT occur before the cycle after RESP.
REQ-011 rdata SHALL hold its value between RESP cycles and SHALL update on every op, including op 0..2.
REQ-012 If the requester drops req after grant, the latched command SHALL still complete, and done SHALL still pulse.
REQ-013 If both requests are high in IDLE, exactly one gnt SHALL pulse; gnt0 and gnt1 SHALL never both be 1, and the same applies to done0/done1.
REQ-014 Requester inputs SHALL be ignored outside IDLE; changes to op/rg/ma/din after grant SHALL NOT affect dp_*.
REQ-015 dp_en SHALL be 1 only in ISSUE; the datapath is required to ignore dp_* when dp_en=0.

Reset
REQ-016 When reset_n is low, the block SHALL immediately reset: state IDLE, rr=0, counter 0, gnt*/done*/dp_en 0, dp_* 0, rdata 0.
REQ-017 Reset asserted mid-command SHALL abort the command with no done pulse; any datapath write already strobed SHALL stand.
REQ-018 Reset release SHALL take effect on the first rising clock edge with reset_n high.

Verification
REQ-019 Single request: req0 with op=0, ma=3, din=3 -> gnt0 at cycle t, dp_en at t+1 with dp_mem=3 and dp_din=3, done0 at t+LAT+2.
REQ-020 Chained sequence on requester 0: op0 ma3 din3; op2 rg0 ma3; op1 rg0 ma4; op3 ma4 -> final rdata=3 with done0.
REQ-021 Contention: req0 and req1 held high continuously -> grants alternate 0,1,0,1, starting with 0 after reset; no cycle has two gnts.
REQ-022 Request drop: req1 falls one cycle after gnt1, with op=3 ma=3 (mem3=3) -> done1 still pulses and rdata=3.
REQ-023 Reset mid-op: reset_n pulsed low during WAIT -> all outputs 0 at once, no done pulse; a later req1 is granted, proving rr=0 and the single-requester rule.
REQ-024 Input stability: op0 changed from 3 to 0 during WAIT -> dp_op stays 3 and dp_en remains 0.

Source files
------------

// File: rtl/reg2mem_arbiter.sv
// rtl/reg2mem_arbiter.sv - two-requester round-robin front end for a reg2mem datapath
//
// Purpose: arbitrates two requesters, latches the winner's command, strobes it
// into the datapath for one cycle, waits LAT cycles for the result, then
// returns it on rdata together with a done pulse to the winner.
//
// Ports:
//   clock, reset_n       clock (rising edge), asynchronous active-low reset
//   req/op/rg/ma/din 0,1 requester command inputs, sampled only in IDLE
//   gnt0, gnt1           one-cycle grant pulse to the winner
//   done0, done1         one-cycle completion pulse to the winner
//   rdata                result of the last completed command
//   dp_en, dp_op, dp_reg, dp_mem, dp_din   command to the datapath
//   dp_out               datapath result, valid LAT cycles after dp_en falls
module reg2mem_arbiter #(
  parameter int OPW = 2,
  parameter int RGW = 3,
  parameter int MAW = 4,
  parameter int DW  = 4,
  parameter int LAT = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [OPW-1:0] op0,
  input  logic [OPW-1:0] op1,
  input  logic [RGW-1:0] rg0,
  input  logic [RGW-1:0] rg1,
  input  logic [MAW-1:0] ma0,
  input  logic [MAW-1:0] ma1,
  input  logic [DW-1:0]  din0,
  input  logic [DW-1:0]  din1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [DW-1:0]  rdata,
  output logic           dp_en,
  output logic [OPW-1:0] dp_op,
  output logic [RGW-1:0] dp_reg,
  output logic [MAW-1:0] dp_mem,
  output logic [DW-1:0]  dp_din,
  input  logic [DW-1:0]  dp_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT lasts LAT cycles: the counter runs 0 .. LAT-1.
  localparam logic [2:0] LAST_WAIT = 3'(LAT - 1);

  state_t         state_q, state_d;
  logic           rr_q, rr_d;
  logic           win_q, win_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [OPW-1:0] op_q, op_d;
  logic [RGW-1:0] rg_q, rg_d;
  logic [MAW-1:0] ma_q, ma_d;
  logic [DW-1:0]  din_q, din_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           pick;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    cnt_d   = '0;
    op_d    = op_q;
    rg_d    = rg_q;
    ma_d    = ma_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    // Pointer decides only under contention; a lone requester always wins.
    pick    = (req0 && req1) ? rr_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = pick;
          rr_d    = ~pick;
          state_d = ISSUE;
          op_d    = pick ? op1  : op0;
          rg_d    = pick ? rg1  : rg0;
          ma_d    = pick ? ma1  : ma0;
          din_d   = pick ? din1 : din0;
          // Grant is combinational; gate it so it is 0 while reset is held.
          gnt0    = reset_n & ~pick;
          gnt1    = reset_n & pick;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        rdata_d = dp_out;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      rg_q    <= '0;
      ma_q    <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rg_q    <= rg_d;
      ma_q    <= ma_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  assign dp_en  = (state_q == ISSUE);
  assign dp_op  = op_q;
  assign dp_reg = rg_q;
  assign dp_mem = ma_q;
  assign dp_din = din_q;
  assign done0  = (state_q == RESP) && !win_q;
  assign done1  = (state_q == RESP) && win_q;
  // Bypass in RESP so the result is visible in the same cycle as done.
  assign rdata  = (state_q == RESP) ? dp_out : rdata_q;

endmodule

// File: tb/tb_reg2mem_arbiter.sv
// tb/tb_reg2mem_arbiter.sv - scoreboard bench for reg2mem_arbiter
module tb_reg2mem_arbiter;

  localparam int OPW = 2;
  localparam int RGW = 3;
  localparam int MAW = 4;
  localparam int DW  = 4;
  localparam int LAT = 2;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [OPW-1:0] op0 = '0, op1 = '0;
  logic [RGW-1:0] rg0 = '0, rg1 = '0;
  logic [MAW-1:0] ma0 = '0, ma1 = '0;
  logic [DW-1:0]  din0 = '0, din1 = '0;
  logic           gnt0, gnt1, done0, done1, dp_en;
  logic [DW-1:0]  rdata, dp_din;
  logic [OPW-1:0] dp_op;
  logic [RGW-1:0] dp_reg;
  logic [MAW-1:0] dp_mem;
  logic [DW-1:0]  dp_out = '0;

  reg2mem_arbiter #(.OPW(OPW), .RGW(RGW), .MAW(MAW), .DW(DW), .LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1), .rg0(rg0), .rg1(rg1),
    .ma0(ma0), .ma1(ma1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .dp_en(dp_en), .dp_op(dp_op), .dp_reg(dp_reg), .dp_mem(dp_mem),
    .dp_din(dp_din), .dp_out(dp_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Environment datapath: executes the strobed op, presents the result
  // exactly LAT cycles after dp_en falls and junk at every other time.
  logic [DW-1:0] env_mem [16];
  logic [DW-1:0] env_reg [8];
  logic [DW-1:0] env_res;
  int            env_ready = -1;

  initial begin
    for (int i = 0; i < 16; i++) env_mem[i] = '0;
    for (int i = 0; i < 8; i++) env_reg[i] = '0;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      env_ready = -1;
    end else if (dp_en) begin
      case (dp_op)
        2'd0: begin env_mem[dp_mem] = dp_din; env_res = dp_din; end
        2'd1: begin env_mem[dp_mem] = env_reg[dp_reg]; env_res = env_reg[dp_reg]; end
        2'd2: begin env_reg[dp_reg] = env_mem[dp_mem]; env_res = env_mem[dp_mem]; end
        default: env_res = env_mem[dp_mem];
      endcase
      env_ready = cyc + LAT + 1;
    end
  end

  always @(posedge clock) begin
    #1;
    dp_out = (cyc == env_ready) ? env_res : DW'($urandom);
  end

  // Reference model and scoreboard.
  typedef struct {
    int             id;
    int             gcyc;
    logic [OPW-1:0] op;
    logic [RGW-1:0] rg;
    logic [MAW-1:0] ma;
    logic [DW-1:0]  din;
    logic [DW-1:0]  res;
  } exp_t;

  exp_t          sb[$];
  int            gnt_log[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] ref_reg [8];
  int            pref = 0;
  int            busy_until = -1;
  logic [DW-1:0] last_rdata = '0;
  exp_t          m_e;
  int            m_w;
  bit            m_idle;
  bit            m_resp;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) ref_reg[i] = '0;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
      pref       = 0;
      busy_until = -1;
      last_rdata = '0;
    end else begin
      check("gnt_excl", gnt0 & gnt1, 0);
      check("done_excl", done0 & done1, 0);
      m_idle = (cyc > busy_until);
      check("gnt_any", gnt0 | gnt1, m_idle && (req0 || req1));
      if (m_idle && (req0 || req1)) begin
        m_w = (req0 && req1) ? pref : (req1 ? 1 : 0);
        check("gnt0_who", gnt0, m_w == 0);
        check("gnt1_who", gnt1, m_w == 1);
        m_e.id   = m_w;
        m_e.gcyc = cyc;
        m_e.op   = m_w ? op1 : op0;
        m_e.rg   = m_w ? rg1 : rg0;
        m_e.ma   = m_w ? ma1 : ma0;
        m_e.din  = m_w ? din1 : din0;
        case (m_e.op)
          2'd0: begin ref_mem[m_e.ma] = m_e.din; m_e.res = m_e.din; end
          2'd1: begin ref_mem[m_e.ma] = ref_reg[m_e.rg]; m_e.res = ref_reg[m_e.rg]; end
          2'd2: begin ref_reg[m_e.rg] = ref_mem[m_e.ma]; m_e.res = ref_mem[m_e.ma]; end
          default: m_e.res = ref_mem[m_e.ma];
        endcase
        sb.push_back(m_e);
        gnt_log.push_back(m_w);
        pref       = 1 - m_w;
        busy_until = cyc + LAT + 2;
      end
      if (sb.size() > 0 && cyc > sb[0].gcyc) begin
        m_e    = sb[0];
        m_resp = (cyc == m_e.gcyc + LAT + 2);
        check("dp_en", dp_en, cyc == m_e.gcyc + 1);
        check("dp_op", dp_op, m_e.op);
        check("dp_reg", dp_reg, m_e.rg);
        check("dp_mem", dp_mem, m_e.ma);
        check("dp_din", dp_din, m_e.din);
        check("done0", done0, m_resp && m_e.id == 0);
        check("done1", done1, m_resp && m_e.id == 1);
        if (m_resp) begin
          check("rdata_resp", rdata, m_e.res);
          last_rdata = m_e.res;
          void'(sb.pop_front());
        end else begin
          check("rdata_hold", rdata, last_rdata);
        end
      end else begin
        check("dp_en_idle", dp_en, 0);
        check("done_idle", done0 | done1, 0);
        check("rdata_hold", rdata, last_rdata);
      end
    end
  end

  // Stimulus helpers.
  task automatic set_fields(input int id, input logic [OPW-1:0] op, input logic [RGW-1:0] rg,
                            input logic [MAW-1:0] ma, input logic [DW-1:0] din);
    if (id == 0) begin op0 = op; rg0 = rg; ma0 = ma; din0 = din; end
    else begin op1 = op; rg1 = rg; ma1 = ma; din1 = din; end
  endtask

  task automatic set_req(input int id, input logic v);
    if (id == 0) req0 = v;
    else req1 = v;
  endtask

  // Raise a request, wait for the grant and the done (both bounded).
  // drop: release req the cycle after grant; wiggle: invert all fields then.
  task automatic req_cmd(input int id, input logic [OPW-1:0] op, input logic [RGW-1:0] rg,
                         input logic [MAW-1:0] ma, input logic [DW-1:0] din,
                         input bit drop, input bit wiggle, output int gc, output int dc);
    bit got;
    gc = -1;
    dc = -1;
    set_fields(id, op, rg, ma, din);
    set_req(id, 1'b1);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if ((id == 0) ? gnt0 : gnt1) begin got = 1; gc = cyc; end
    end
    check("gnt_seen", got, 1);
    if (!got) begin
      set_req(id, 1'b0);
      return;
    end
    @(posedge clock); #1;
    if (drop) set_req(id, 1'b0);
    if (wiggle) set_fields(id, ~op, ~rg, ~ma, ~din);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if ((id == 0) ? done0 : done1) begin got = 1; dc = cyc; end
    end
    check("done_seen", got, 1);
    @(posedge clock); #1;
    set_req(id, 1'b0);
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, "_gnt"}, {gnt0, gnt1}, 0);
    check({nm, "_done"}, {done0, done1}, 0);
    check({nm, "_dp_en"}, dp_en, 0);
    check({nm, "_dp"}, {dp_op, dp_reg, dp_mem, dp_din}, 0);
    check({nm, "_rdata"}, rdata, 0);
  endtask

  task automatic rand_agent(input int id, input int n);
    int gc, dc, k;
    for (int i = 0; i < n; i++) begin
      k = int'($urandom_range(0, 3));
      if (k > 0) begin
        repeat (k) @(posedge clock);
        #1;
      end
      req_cmd(id, OPW'($urandom), RGW'($urandom), MAW'($urandom), DW'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, gc, dc);
    end
  endtask

  int gc, dc, s, n;

  initial begin
    #1;
    check_zero_outputs("reset");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single request and its latency.
    req_cmd(0, 2'd0, 3'd0, 4'd3, 4'd3, 0, 0, gc, dc);
    check("lat_single", dc - gc, LAT + 2);

    // Chained sequence; the last op also has its inputs changed after grant.
    req_cmd(0, 2'd2, 3'd0, 4'd3, 4'd0, 0, 0, gc, dc);
    req_cmd(0, 2'd1, 3'd0, 4'd4, 4'd0, 0, 0, gc, dc);
    req_cmd(0, 2'd3, 3'd0, 4'd4, 4'd0, 0, 1, gc, dc);
    @(negedge clock);
    check("chain_rdata", rdata, 3);

    // Requester 1 drops req the cycle after its grant.
    req_cmd(1, 2'd3, 3'd0, 4'd3, 4'd0, 1, 0, gc, dc);
    check("drop_lat", dc - gc, LAT + 2);
    check("drop_rdata", rdata, 3);

    // Contention from a fresh reset: grants must alternate starting at 0.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    s = gnt_log.size();
    fork
      begin
        for (int i = 0; i < 3; i++) req_cmd(0, 2'd3, 3'd0, 4'd3, 4'd0, 0, 0, gc, dc);
      end
      begin
        int gc1, dc1;
        for (int i = 0; i < 3; i++) req_cmd(1, 2'd3, 3'd0, 4'd4, 4'd0, 0, 0, gc1, dc1);
      end
    join
    check("rr_count", gnt_log.size() - s, 6);
    for (int i = 0; i < 6 && s + i < gnt_log.size(); i++) check("rr_order", gnt_log[s + i], i % 2);

    // Reset during WAIT aborts without done; the strobed write stands.
    set_fields(0, 2'd0, 3'd0, 4'd5, 4'd7);
    req0 = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!gnt0 && n < 50);
    check("abort_gnt", gnt0, 1);
    @(posedge clock); #1 req0 = 1'b0;
    @(posedge clock); #2;
    set_fields(1, 2'd3, 3'd0, 4'd5, 4'd0);
    req1 = 1'b1;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    req_cmd(1, 2'd3, 3'd0, 4'd5, 4'd0, 0, 0, gc, dc);
    check("abort_next_who", gnt_log[gnt_log.size() - 1], 1);
    check("abort_write_kept", rdata, 7);

    // Randomized traffic from both requesters.
    fork
      rand_agent(0, 20);
      rand_agent(1, 20);
    join
    repeat (4) @(posedge clock);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
